// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller: address split,
// beat count, FSM state encoding and line-address helper.
package dcache_pkg;

    localparam int ADDR_LEN = 32;
    localparam int IDX_LEN  = 6;
    localparam int OFF_LEN  = 6;
    localparam int TAG_LEN  = ADDR_LEN - IDX_LEN - OFF_LEN;
    localparam int DATA_LEN = 64;
    localparam int MASK_W   = DATA_LEN / 8;
    localparam int BEAT_W   = OFF_LEN - 3;
    localparam int BEATS    = 1 << BEAT_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMP    = 2'd1,
        ST_WB     = 2'd2,
        ST_REFILL = 2'd3
    } state_e;

    // Line-aligned byte address built from a tag and a set index.
    function automatic logic [ADDR_LEN-1:0] line_addr(input logic [TAG_LEN-1:0] tag,
                                                      input logic [IDX_LEN-1:0] idx);
        return {tag, idx, {OFF_LEN{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Bundle of CPU, tag-array, data-array and memory-bus signals around the
// cache controller. master = controller side, slave = surrounding system.
interface dcache_ctrl_if;
    import dcache_pkg::*;

    // LSU side
    logic                cpu_valid_i;
    logic                cpu_ready_o;
    logic [ADDR_LEN-1:0] cpu_addr_i;
    logic                cpu_we_i;
    logic [DATA_LEN-1:0] cpu_wdata_i;
    logic [MASK_W-1:0]   cpu_wmask_i;
    logic [DATA_LEN-1:0] cpu_rdata_o;
    logic                cpu_done_o;
    // tag array
    logic [TAG_LEN-1:0]  tag_o;
    logic [IDX_LEN-1:0]  tag_index_o;
    logic                tag_dirty_o;
    logic                tag_we_o;
    logic                tag_hit_i;
    logic                tag_dirty_i;
    logic [TAG_LEN-1:0]  tag_rd_i;
    // data array
    logic [IDX_LEN-1:0]  data_index_o;
    logic [BEAT_W-1:0]   data_beat_o;
    logic                data_we_o;
    logic [MASK_W-1:0]   data_wmask_o;
    logic [DATA_LEN-1:0] data_wdata_o;
    logic [DATA_LEN-1:0] data_rdata_i;
    // memory bus
    logic                mem_req_o;
    logic                mem_we_o;
    logic [ADDR_LEN-1:0] mem_addr_o;
    logic [DATA_LEN-1:0] mem_wdata_o;
    logic [DATA_LEN-1:0] mem_rdata_i;
    logic                mem_ack_i;

    modport master (
        input  cpu_valid_i, cpu_addr_i, cpu_we_i, cpu_wdata_i, cpu_wmask_i,
        output cpu_ready_o, cpu_rdata_o, cpu_done_o,
        output tag_o, tag_index_o, tag_dirty_o, tag_we_o,
        input  tag_hit_i, tag_dirty_i, tag_rd_i,
        output data_index_o, data_beat_o, data_we_o, data_wmask_o, data_wdata_o,
        input  data_rdata_i,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport slave (
        output cpu_valid_i, cpu_addr_i, cpu_we_i, cpu_wdata_i, cpu_wmask_i,
        input  cpu_ready_o, cpu_rdata_o, cpu_done_o,
        input  tag_o, tag_index_o, tag_dirty_o, tag_we_o,
        output tag_hit_i, tag_dirty_i, tag_rd_i,
        input  data_index_o, data_beat_o, data_we_o, data_wmask_o, data_wdata_o,
        output data_rdata_i,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );

endinterface

// File: rtl/dcache_beat_cnt.sv
// Beat counter for line bursts: increments per accepted beat, wraps
// naturally after the last beat, and flags the final beat of a line.
module dcache_beat_cnt
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [BEAT_W-1:0] cnt_o,
    output logic              last_o
);

    logic [BEAT_W-1:0] cnt_q;
    logic [BEAT_W-1:0] cnt_d;

    // Next count: clear wins over increment; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped data-cache controller: one outstanding load/store, tag
// compare, dirty-victim writeback burst, line refill burst, then replay.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    dcache_ctrl_if.master bus
);

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [ADDR_LEN-1:0] victim_q, victim_d;
    // Set for the single idle cycle between the writeback and refill bursts.
    logic                gap_q, gap_d;

    logic                cnt_inc;
    logic                cnt_clr;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                beat_last;

    logic [TAG_LEN-1:0]  req_tag;
    logic [IDX_LEN-1:0]  req_idx;
    logic [BEAT_W-1:0]   req_beat;
    logic                unused_byte_off;

    assign req_tag         = addr_q[ADDR_LEN-1 -: TAG_LEN];
    assign req_idx         = addr_q[OFF_LEN +: IDX_LEN];
    assign req_beat        = addr_q[3 +: BEAT_W];
    assign unused_byte_off = ^addr_q[2:0];

    dcache_beat_cnt u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .cnt_o  (beat_cnt),
        .last_o (beat_last)
    );

    // Next-state and output decode; every output defaults to 0 so IDLE is quiet.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        victim_d = victim_q;
        gap_d    = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;

        bus.cpu_ready_o  = 1'b0;
        bus.cpu_rdata_o  = '0;
        bus.cpu_done_o   = 1'b0;
        bus.tag_o        = '0;
        bus.tag_index_o  = '0;
        bus.tag_dirty_o  = 1'b0;
        bus.tag_we_o     = 1'b0;
        bus.data_index_o = '0;
        bus.data_beat_o  = '0;
        bus.data_we_o    = 1'b0;
        bus.data_wmask_o = '0;
        bus.data_wdata_o = '0;
        bus.mem_req_o    = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_wdata_o  = '0;

        unique case (state_q)
            ST_IDLE: begin
                bus.cpu_ready_o = 1'b1;
                cnt_clr         = 1'b1;
                if (bus.cpu_valid_i) begin
                    addr_d  = bus.cpu_addr_i;
                    we_d    = bus.cpu_we_i;
                    wdata_d = bus.cpu_wdata_i;
                    wmask_d = bus.cpu_wmask_i;
                    state_d = ST_CMP;
                end
            end

            ST_CMP: begin
                bus.tag_index_o  = req_idx;
                bus.tag_o        = req_tag;
                bus.data_index_o = req_idx;
                bus.data_beat_o  = req_beat;
                if (bus.tag_hit_i) begin
                    bus.cpu_done_o = 1'b1;
                    state_d        = ST_IDLE;
                    if (we_q) begin
                        bus.data_we_o    = 1'b1;
                        bus.data_wmask_o = wmask_q;
                        bus.data_wdata_o = wdata_q;
                        bus.tag_we_o     = 1'b1;
                        bus.tag_dirty_o  = 1'b1;
                    end else begin
                        bus.cpu_rdata_o = bus.data_rdata_i;
                    end
                end else if (bus.tag_dirty_i) begin
                    victim_d = line_addr(bus.tag_rd_i, req_idx);
                    state_d  = ST_WB;
                end else begin
                    state_d = ST_REFILL;
                end
            end

            ST_WB: begin
                bus.tag_index_o  = req_idx;
                bus.tag_o        = req_tag;
                bus.data_index_o = req_idx;
                bus.data_beat_o  = beat_cnt;
                bus.mem_req_o    = 1'b1;
                bus.mem_we_o     = 1'b1;
                bus.mem_addr_o   = victim_q;
                bus.mem_wdata_o  = bus.data_rdata_i;
                if (bus.mem_ack_i) begin
                    cnt_inc = 1'b1;
                    if (beat_last) begin
                        gap_d   = 1'b1;
                        state_d = ST_REFILL;
                    end
                end
            end

            ST_REFILL: begin
                bus.tag_index_o  = req_idx;
                bus.tag_o        = req_tag;
                bus.data_index_o = req_idx;
                bus.data_beat_o  = beat_cnt;
                if (!gap_q) begin
                    bus.mem_req_o  = 1'b1;
                    bus.mem_addr_o = line_addr(req_tag, req_idx);
                    if (bus.mem_ack_i) begin
                        bus.data_we_o    = 1'b1;
                        bus.data_wmask_o = '1;
                        bus.data_wdata_o = bus.mem_rdata_i;
                        cnt_inc          = 1'b1;
                        if (beat_last) begin
                            bus.tag_we_o    = 1'b1;
                            bus.tag_dirty_o = 1'b0;
                            state_d         = ST_CMP;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-request registers; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            victim_q <= '0;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            victim_q <= victim_d;
            gap_q    <= gap_d;
        end
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Initiator-side controller for the data-cache tag array and data array; sits between the LSU and the memory bus.
- Accepts one load/store at a time and drives the tag array's lookup/write port.
- On a hit, reads or writes the data array.
- On a miss, writes back a dirty victim line in a beat burst, refills the line from memory, writes the new tag, then replays the access.
- Direct-mapped; the tag array supplies combinational read and one-cycle write.

Parameters:
ADDR_LEN, 32, CPU/memory address width
TAG_LEN, 20, tag width (ADDR_LEN-IDX_LEN-OFF_LEN)
IDX_LEN, 6, set index width
OFF_LEN, 6, line offset width (64-byte line)
DATA_LEN, 64, beat/word width; BEATS = 2^(OFF_LEN-3) = 8

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_valid_i  in  1  request valid
cpu_ready_o  out  1  controller idle, request accepted when valid&ready
cpu_addr_i  in  ADDR_LEN  byte address
cpu_we_i  in  1  1=store
cpu_wdata_i  in  DATA_LEN  store data (word aligned)
cpu_wmask_i  in  8  byte enables
cpu_rdata_o  out  DATA_LEN  load data, valid with cpu_done_o
cpu_done_o  out  1  one-cycle completion pulse
tag_o  out  TAG_LEN  tag to compare/write
tag_index_o  out  IDX_LEN  tag array index
tag_dirty_o  out  1  dirty bit to write
tag_we_o  out  1  tag write enable
tag_hit_i  in  1  combinational hit from tag array
tag_dirty_i  in  1  stored dirty bit
tag_rd_i  in  TAG_LEN  stored tag (victim)
data_index_o  out  IDX_LEN  data array set
data_beat_o  out  OFF_LEN-3  word within line
data_we_o  out  1  data write enable
data_wmask_o  out  8  byte enables
data_wdata_o  out  DATA_LEN  write data
data_rdata_i  in  DATA_LEN  combinational read data
mem_req_o  out  1  burst request, held for whole burst
mem_we_o  out  1  1=writeback, 0=refill
mem_addr_o  out  ADDR_LEN  line-aligned burst address
mem_wdata_o  out  DATA_LEN  writeback beat
mem_rdata_i  in  DATA_LEN  refill beat
mem_ack_i  in  1  beat accepted/returned this cycle

Behaviour:
- Reset: state IDLE, beat counter 0, latched request cleared.
  - All outputs 0 except cpu_ready_o=1.
  - Reset mid-burst aborts; mem_req_o is low the cycle after rst.
- States: IDLE, CMP, WB, REFILL.
- IDLE:
  - cpu_ready_o=1.
  - On cpu_valid_i, latch addr/we/wdata/wmask and go to CMP.
- CMP:
  - tag_index_o=latched idx, tag_o=latched tag.
  - Hit & load: cpu_rdata_o=data_rdata_i at beat addr[OFF_LEN-1:3]; cpu_done_o=1; go to IDLE.
  - Hit & store: data_we_o=1 with latched mask/data; tag_we_o=1, tag_dirty_o=1; cpu_done_o=1; go to IDLE.
  - Miss & tag_dirty_i: latch victim address {tag_rd_i, idx, 0}; go to WB.
  - Miss & clean: go to REFILL.
- Hit latency: done pulse 1 cycle after acceptance; next request accepted the cycle after done.
- WB:
  - mem_req_o=1, mem_we_o=1, mem_addr_o=victim address.
  - data_beat_o=counter, mem_wdata_o=data_rdata_i.
  - Each mem_ack_i increments the counter.
  - On the ack with counter==BEATS-1: counter wraps to 0, mem_req_o drops next cycle, go to REFILL.
- REFILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={tag, idx, 0}.
  - On each mem_ack_i: data_we_o=1, wmask=all ones, wdata=mem_rdata_i, beat=counter; counter increments.
  - On the last ack, same cycle: tag_we_o=1, tag_dirty_o=0, tag_o=latched tag; counter wraps; go to CMP. Replay then hits.
- No ack: state and counter hold; mem outputs stable.
- mem_req_o is deasserted for exactly one cycle between WB and REFILL.
- cpu_valid_i outside IDLE is ignored.
- cpu_done_o and tag_we_o/data_we_o are single-cycle pulses.
- Address split: tag=addr[31:12], idx=addr[11:6], beat=addr[5:3].

Decomposition:
- Shared package dcache_pkg:
  - state encodings (IDLE/CMP/WB/REFILL)
  - BEATS constant
  - address-split localparams TAG_LEN/IDX_LEN/OFF_LEN
- One natural sub-module: dcache_beat_cnt (OFF_LEN-3 bit counter with inc/clear and last-beat flag).

Test Plan:
- Cold load 0x80001008 after reset:
  - REFILL burst at mem_addr_o=0x80001000, 8 acks.
  - Tag written dirty=0 with the last ack.
  - cpu_done_o with cpu_rdata_o = beat1 of refill data.
- Load hit to 0x80001010 -> cpu_done_o one cycle after acceptance; no mem_req_o.
- Store 0x80001000, wdata 0x11223344_55667788, mask 0x0F -> data_we_o with mask 0x0F; tag_we_o with dirty=1; done in 1 cycle.
- Load 0x90001000 (same idx 0, dirty victim):
  - WB at 0x80001000, 8 beats carrying stored line (beat0 low bytes = 0x55667788).
  - mem_req_o low 1 cycle.
  - REFILL at 0x90001000, then done.
- Refill with mem_ack_i every third cycle -> counter, mem_addr_o, and data_beat_o hold between acks; exactly 8 data writes.
- Assert rst at beat 4 of a REFILL -> next cycle mem_req_o=0, state IDLE, cpu_ready_o=1; subsequent load to the same line misses again.
